// File: rtl/fetch_prefetch_queue.sv
// Fetch front-end: owns the PC, issues one outstanding imem request and queues {instr, pc+4}.
// Head visible one cycle after ack; decode stall holds the head; the queue stops fetching when full.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, WAIT_DROP} state_t;

  state_t        state_q;
  logic [31:0]   fetch_pc_q;
  logic          req_q;
  logic [31:0]   addr_q;

  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc4_mem_q   [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   count_q, count_d;

  logic          push, pop, space;
  logic [31:0]   pc_inc, redirect_pc_al;

  assign instr_valid    = (count_q != '0);
  assign pop            = instr_valid & ~stall & ~redirect;
  assign push           = (state_q == WAIT) & imem_ack & ~redirect;
  assign pc_inc         = fetch_pc_q + 32'd4;
  assign redirect_pc_al = redirect_pc & 32'hFFFF_FFFC;

  // Occupancy after this edge decides whether another request may be issued.
  assign count_d = redirect ? '0
                 : count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign space   = (count_d < (AW+1)'(DEPTH));

  assign imem_req     = req_q;
  assign imem_addr    = addr_q;
  assign instr_out    = instr_valid ? instr_mem_q[head_q] : 32'h0;
  assign pc_plus4_out = instr_valid ? pc4_mem_q[head_q]   : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect) begin
            fetch_pc_q <= redirect_pc_al;
          end else if (space) begin
            req_q   <= 1'b1;
            addr_q  <= fetch_pc_q;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            fetch_pc_q <= redirect_pc_al;
            if (imem_ack) begin
              req_q   <= 1'b0;
              state_q <= IDLE;
            end else begin
              state_q <= WAIT_DROP;
            end
          end else if (imem_ack) begin
            fetch_pc_q <= pc_inc;
            if (space) begin
              addr_q <= pc_inc;
            end else begin
              req_q   <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        WAIT_DROP: begin
          // The stale response still has to be absorbed before a new request.
          if (redirect) fetch_pc_q <= redirect_pc_al;
          if (imem_ack) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (redirect) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + AW'(1);
      if (pop)  head_q <= head_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[tail_q] <= imem_rdata;
      pc4_mem_q[tail_q]   <= pc_inc;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomised and directed bench for fetch_prefetch_queue against an address-stream reference model.
module tb_fetch_prefetch_queue;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h00400000;

  logic        clk = 1'b0;
  logic        rst_n, redirect, stall, imem_ack, imem_req, instr_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, instr_out, pc_plus4_out;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_out(instr_out),
    .pc_plus4_out(pc_plus4_out)
  );

  int checks = 0, errors = 0;

  // Reference model: queue of fetched addresses, next expected fetch address, request tracking.
  logic [31:0] mq[$];
  logic [31:0] exp_fetch, cur_addr;
  logic        outstanding, drop;
  int          wait_cnt, lat_cur, lat_set, pops;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    mq.delete();
    exp_fetch   = RST_PC;
    cur_addr    = RST_PC;
    outstanding = 1'b0;
    drop        = 1'b0;
    wait_cnt    = 0;
    lat_cur     = 0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cyc(input logic redir, input logic [31:0] rpc, input logic stl, input logic stray);
    logic req_obs, acked, pop_m, push_m;
    req_obs = imem_req;
    if (outstanding) begin
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_held", imem_addr, cur_addr);
    end
    if (req_obs && !outstanding) begin
      chk("req_addr", imem_addr, exp_fetch);
      cur_addr = exp_fetch;
      wait_cnt = 0;
      lat_cur  = lat_set;
    end
    if (req_obs) chk("req_space", 32'(mq.size() < DEPTH), 32'd1);
    chk("valid", 32'(instr_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("instr", instr_out, word(mq[0]));
      chk("pc4", pc_plus4_out, mq[0] + 32'd4);
    end else begin
      chk("instr_empty", instr_out, 32'h0);
      chk("pc4_empty", pc_plus4_out, 32'h0);
    end

    redirect    = redir;
    redirect_pc = rpc;
    stall       = stl;
    acked       = req_obs && (wait_cnt >= lat_cur);
    imem_ack    = acked || (stray && !req_obs);
    imem_rdata  = acked ? word(cur_addr) : 32'hDEADBEEF;

    @(posedge clk);
    pop_m  = (mq.size() > 0) && !stl && !redir;
    push_m = acked && !drop && !redir;
    if (redir) begin
      mq.delete();
      exp_fetch = rpc & 32'hFFFFFFFC;
    end else begin
      if (pop_m) begin
        void'(mq.pop_front());
        pops++;
      end
      if (push_m) begin
        mq.push_back(cur_addr);
        exp_fetch = cur_addr + 32'd4;
      end
    end
    drop        = acked ? 1'b0 : (drop || (redir && req_obs));
    outstanding = req_obs && !acked;
    if (req_obs && !acked) wait_cnt++;
    @(negedge clk);
    imem_ack = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic do_reset();
    imem_ack = 1'b0;
    redirect = 1'b0;
    stall    = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic found;
    rst_n = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; lat_set = 0; pops = 0;
    reset_model();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_pc4", pc_plus4_out, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle memory, no stall: one instruction per cycle after two warm-up cycles.
    lat_set = 0;
    repeat (2) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    pops = 0;
    repeat (20) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("throughput", 32'(pops), 32'd20);

    // Stall from reset: queue fills, fetch stops, then drains and resumes at +0x10.
    do_reset();
    repeat (10) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("full_req_low", 32'(imem_req), 32'd0);
    chk("full_head", instr_out, word(RST_PC));
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      if (imem_req) found = 1'b1;
    end
    chk("resume_req", 32'(found), 32'd1);
    chk("resume_addr", imem_addr, 32'h00400010);
    repeat (8) cyc(1'b0, 32'h0, 1'b0, 1'b0);

    // Redirect while a slow request to 0x00400008 is outstanding.
    do_reset();
    lat_set = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (imem_req && imem_addr == 32'h00400008) found = 1'b1;
      else cyc(1'b0, 32'h0, 1'b0, 1'b0);
    end
    chk("find_req8", 32'(found), 32'd1);
    cyc(1'b1, 32'h00400100, 1'b0, 1'b0);
    chk("redir_flush", 32'(instr_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (instr_valid) found = 1'b1;
      else cyc(1'b0, 32'h0, 1'b0, 1'b0);
    end
    chk("redir_first", instr_out, word(32'h00400100));

    // Redirect coinciding with an ack, then with a pop of a 3-entry queue.
    lat_set = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_req) found = 1'b1;
      else cyc(1'b0, 32'h0, 1'b0, 1'b0);
    end
    cyc(1'b1, 32'h00400200, 1'b0, 1'b0);
    chk("redir_ack_flush", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 20 && mq.size() != 3; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 32'h00400300, 1'b0, 1'b0);
    chk("redir_pop_flush", 32'(instr_valid), 32'd0);
    repeat (6) cyc(1'b0, 32'h0, 1'b0, 1'b0);

    // Reset pulse during an outstanding request, then a stray ack.
    lat_set = 3;
    for (int i = 0; i < 10 && !outstanding; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_addr", imem_addr, RST_PC);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (10) cyc(1'b0, 32'h0, 1'b0, 1'b0);

    // Address wrap with an unaligned redirect target.
    lat_set = 0;
    cyc(1'b1, 32'hFFFFFFF7, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mq.size() > 0 && mq[0] == 32'hFFFFFFFC) found = 1'b1;
      else cyc(1'b0, 32'h0, 1'b0, 1'b0);
    end
    chk("wrap_found", 32'(found), 32'd1);
    chk("wrap_pc4", pc_plus4_out, 32'h0);
    repeat (6) cyc(1'b0, 32'h0, 1'b0, 1'b0);

    // Random traffic: variable latency, stalls and redirects.
    for (int i = 0; i < 1500; i++) begin
      logic        r, s;
      logic [31:0] t;
      lat_set = $urandom_range(0, 3);
      s = ($urandom_range(0, 9) < 3);
      r = ($urandom_range(0, 19) == 0);
      t = $urandom;
      if ($urandom_range(0, 3) == 0) t = 32'hFFFFFFF0 | {28'h0, t[3:0]};
      cyc(r, t, s, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Instruction fetch front-end placed between the instruction memory and the fetch-to-decode pipeline register.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned instructions with their PC+4 in a small FIFO and presents them to decode under decode-stall control.
- Handles branch, jump and jr redirects: flushes the queue and discards any in-flight response.

Parameters:
DEPTH, 4, number of queue entries (power of 2, 2..16)
RESET_PC, 32'h00400000, fetch address after reset

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
redirect  in  1  taken branch / jump / jr resolved in decode (PCSrcD | Jump | Jr)
redirect_pc  in  32  target address for redirect
stall  in  1  decode stall (StallD); head entry is not consumed while high
imem_req  out  1  instruction memory request
imem_addr  out  32  word-aligned request address
imem_ack  in  1  memory response valid, one-cycle pulse
imem_rdata  in  32  instruction word, valid with imem_ack
instr_valid  out  1  queue head is valid
instr_out  out  32  head instruction (32'h0 when empty)
pc_plus4_out  out  32  head PC+4 (32'h0 when empty)

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_PC, queue count=0, head/tail pointers=0, imem_req=0, imem_addr=RESET_PC, FSM=IDLE, instr_valid=0, instr_out=0, pc_plus4_out=0.
- FSM states: IDLE (no request outstanding), WAIT (request outstanding, response kept), WAIT_DROP (request outstanding, response discarded).
- At most one outstanding request. imem_req and imem_addr are registered and held constant from assertion until the cycle imem_ack=1.
- IDLE -> WAIT: when count + (push this cycle) - (pop this cycle) < DEPTH and no redirect. imem_req=1 and imem_addr=fetch_pc on the next cycle.
- WAIT with imem_ack: push {imem_rdata, fetch_pc+4} at the tail, then fetch_pc += 4.
  - Same edge: issue the next request (remain in WAIT) if there is space.
  - Otherwise drop imem_req and go to IDLE.
- WAIT with redirect: go to WAIT_DROP. fetch_pc=redirect_pc.
- WAIT_DROP with imem_ack: discard the data, no push. Go to IDLE and issue the request to redirect_pc on the following cycle.
- Redirect in WAIT on the same cycle as imem_ack: the acked word is discarded and the FSM goes to IDLE.
- Redirect in IDLE: fetch_pc=redirect_pc and request issued the next cycle.
- Redirect always clears the queue: count=0, pointers=0, instr_valid=0 next cycle. Redirect has priority over push and pop.
- Pop: instr_valid & ~stall & ~redirect advances the head.
- Simultaneous push and pop keeps count unchanged. With count==DEPTH, no new request is issued.
- instr_out and pc_plus4_out are combinational reads of the head entry, gated to 0 when count==0.
- No bypass: an ack at edge N makes data visible at instr_out after edge N, i.e. minimum fetch latency is 1 cycle beyond the ack.
- Address arithmetic is modulo 2^32: 32'hFFFFFFFC + 4 = 0. redirect_pc[1:0] is ignored (forced to 00).
- Reset asserted mid-request: everything returns to reset values immediately. A late imem_ack after reset release while in IDLE is ignored.
- Steady state with 1-cycle memory and no stall: one instruction per cycle.

Test Plan:
- Reset release, memory acks every cycle, stall=0 -> imem_addr sequence 0x00400000, 0x00400004, 0x00400008...; instr_out shows the matching words one per cycle; pc_plus4_out=0x00400004, 0x00400008...
- stall=1 held for 10 cycles with DEPTH=4 -> exactly 4 entries buffered, imem_req low while full. Release stall -> 4 entries drain in order, fetch resumes at 0x00400010.
- Redirect to 0x00400100 while a request to 0x00400008 is outstanding with ack delayed 3 cycles -> the returned word is discarded, instr_valid=0, next imem_addr=0x00400100, first valid instr_out is the word at 0x00400100.
- Redirect coinciding with imem_ack, and redirect coinciding with a pop of a 3-entry queue -> no push, queue empty next cycle, next request to redirect_pc.
- rst_n pulsed low while in WAIT -> imem_req=0 and count=0 immediately; after release the stray ack is ignored and fetch restarts at 0x00400000.
- fetch_pc=0xFFFFFFFC -> pushed pc_plus4_out=0x00000000, next imem_addr=0x00000000.
